// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the transmit FSM state type, the parity-sense constants, the default
// baud divisor, the byte type and the parity helper. The transmit stage uses
// it now, and the planned receive stage will use it too.
package uart_pkg;

  // Transmit FSM states, in frame order
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  typedef logic [7:0] uart_byte_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // 100 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Parity bit that goes on the line: XOR of the data bits, inverted for odd sense
  function automatic logic parity_bit(input uart_byte_t data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the byte FIFO / control logic and fifo_uart_tx.
//   enable     : permits the transmitter to start a new frame
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO registered read data (valid the cycle after a pop)
//   fifo_rd_en : pop strobe from the transmitter
//   tx         : serial line
//   busy       : transmitter is not idle
//   tx_done    : pulse on the last cycle of the final stop bit
// master = transmitter side, slave = FIFO/control side.
interface fifo_uart_tx_if;
  logic                 enable;
  logic                 fifo_empty;
  uart_pkg::uart_byte_t fifo_data;
  logic                 fifo_rd_en;
  logic                 tx;
  logic                 busy;
  logic                 tx_done;

  modport master (
    input  enable, fifo_empty, fifo_data,
    output fifo_rd_en, tx, busy, tx_done
  );

  modport slave (
    output enable, fifo_empty, fifo_data,
    input  fifo_rd_en, tx, busy, tx_done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer shared by the UART transmit and receive stages.
// A down-counter that load sets to CLKS_PER_BIT-1; tick is high while the
// count is zero, marking the last clock of the current bit.
//   clk, rst : clock, asynchronous active-high reset (count resets to 0)
//   load     : restart the count for a new bit
//   tick     : last cycle of the current bit period
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);
  localparam int                CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count down to zero and hold there until reloaded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= RELOAD;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmit stage that drains a byte FIFO.
// Pops one byte per frame and sends start bit, 8 data bits LSB first,
// optional parity bit and 1 or 2 stop bits.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_uart_tx_if master (enable, fifo_empty, fifo_data in;
//              fifo_rd_en, tx, busy, tx_done out)
// Outputs depend only on registers, so enable/fifo_empty never reach an
// output combinationally.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = PAR_EVEN,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master bus
);
  tx_state_t  state_r, state_s;
  logic [2:0] bit_idx_r, bit_idx_s;
  uart_byte_t shift_r, shift_s;
  logic       parity_r, parity_s;
  logic       stop_cnt_r, stop_cnt_s;
  logic       tx_r, tx_s;
  logic       load_s, tick_s, stop_last_s, start_ok_s;

  // fifo_empty is only looked at in IDLE and in the final STOP cycle, and
  // POP always follows one of those, so a pop never hits an empty FIFO.
  assign start_ok_s  = bus.enable & ~bus.fifo_empty;
  assign stop_last_s = (stop_cnt_r == 1'(STOP_BITS - 1));

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load_s),
    .tick (tick_s)
  );

  // Next-state, datapath and bit-timer reload decisions
  always_comb begin
    state_s    = state_r;
    bit_idx_s  = bit_idx_r;
    shift_s    = shift_r;
    parity_s   = parity_r;
    stop_cnt_s = stop_cnt_r;
    load_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_s = POP;
        else            state_s = IDLE;
      end
      POP: state_s = LOAD;
      LOAD: begin
        shift_s    = bus.fifo_data;
        parity_s   = parity_bit(bus.fifo_data, PARITY_ODD ? PAR_ODD : PAR_EVEN);
        bit_idx_s  = 3'd0;
        stop_cnt_s = 1'b0;
        load_s     = 1'b1;
        state_s    = START;
      end
      START: begin
        if (tick_s) begin
          load_s  = 1'b1;
          state_s = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          load_s    = 1'b1;
          shift_s   = {1'b0, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;  // wraps 7 -> 0 on exit
          if (bit_idx_r == 3'd7) state_s = PARITY_EN ? PARITY : STOP;
          else                   state_s = DATA;
        end else begin
          state_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          load_s  = 1'b1;
          state_s = STOP;
        end else begin
          state_s = PARITY;
        end
      end
      STOP: begin
        if (tick_s && stop_last_s) begin
          if (start_ok_s) state_s = POP;
          else            state_s = IDLE;
        end else if (tick_s) begin
          load_s     = 1'b1;
          stop_cnt_s = stop_cnt_r + 1'b1;
          state_s    = STOP;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Line level for the cycle being entered, so tx is a plain flop output
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = parity_s;
      default: tx_s = 1'b1;
    endcase
  end

  // State and datapath registers; reset drives the line high at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      parity_r   <= 1'b0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
    end else begin
      state_r    <= state_s;
      bit_idx_r  <= bit_idx_s;
      shift_r    <= shift_s;
      parity_r   <= parity_s;
      stop_cnt_r <= stop_cnt_s;
      tx_r       <= tx_s;
    end
  end

  assign bus.tx         = tx_r;
  assign bus.fifo_rd_en = (state_r == POP);
  assign bus.busy       = (state_r != IDLE);
  assign bus.tx_done    = (state_r == STOP) & tick_s & stop_last_s;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4.
// Three instances: 0 = no parity, 1 stop; 1 = even parity, 2 stops;
// 2 = odd parity, 1 stop. One FIFO model feeds the selected instance.
module tb_fifo_uart_tx;
  localparam int C    = 4;
  localparam int MAXC = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_uart_tx_if if0();
  fifo_uart_tx_if if1();
  fifo_uart_tx_if if2();

  int         sel;
  logic       en_v, emp_v;
  logic [7:0] dat_v;
  logic [7:0] fq[$];      // FIFO contents as the bench sees them
  logic [7:0] mbytes[$];  // bytes the model expects on the line, in order

  assign if0.enable     = (sel == 0) ? en_v : 1'b0;
  assign if1.enable     = (sel == 1) ? en_v : 1'b0;
  assign if2.enable     = (sel == 2) ? en_v : 1'b0;
  assign if0.fifo_empty = (sel == 0) ? emp_v : 1'b1;
  assign if1.fifo_empty = (sel == 1) ? emp_v : 1'b1;
  assign if2.fifo_empty = (sel == 2) ? emp_v : 1'b1;
  assign if0.fifo_data  = dat_v;
  assign if1.fifo_data  = dat_v;
  assign if2.fifo_data  = dat_v;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  fifo_uart_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [2:0] w_tx, w_rd, w_busy, w_done;
  assign w_tx   = {if2.tx, if1.tx, if0.tx};
  assign w_rd   = {if2.fifo_rd_en, if1.fifo_rd_en, if0.fifo_rd_en};
  assign w_busy = {if2.busy, if1.busy, if0.busy};
  assign w_done = {if2.tx_done, if1.tx_done, if0.tx_done};

  // per cycle: [3]=tx [2]=rd_en [1]=busy [0]=tx_done
  logic [3:0] cap[MAXC];
  logic [3:0] ex[MAXC];
  int checks = 0;
  int errors = 0;

  function automatic bit pen_of(input int i);  return i != 0; endfunction
  function automatic bit odd_of(input int i);  return i == 2; endfunction
  function automatic int stop_of(input int i); return (i == 1) ? 2 : 1; endfunction

  // One clock; FIFO model pops on a strobe seen before the edge and presents data after it
  task automatic step();
    logic [2:0] pop;
    pop = w_rd;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (pop[k]) begin
        checks++;
        if (k != sel || fq.size() == 0) begin
          errors++;
          $display("FAIL pop_on_empty: instance %0d popped, fifo had %0d bytes for it, required no pop",
                   k, (k == sel) ? fq.size() : 0);
        end else begin
          dat_v = fq.pop_front();
        end
      end
    end
    emp_v = (fq.size() == 0);
  endtask

  task automatic load_byte(input logic [7:0] b);
    fq.push_back(b);
    mbytes.push_back(b);
    emp_v = 1'b0;
  endtask

  // Record n cycles of the selected instance; enable drops at cycle drop_at
  task automatic capture(input int n, input int drop_at);
    for (int k = 0; k < n; k++) begin
      if (k == drop_at) en_v = 1'b0;
      cap[k] = {w_tx[sel], w_rd[sel], w_busy[sel], w_done[sel]};
      step();
    end
  endtask

  // Expected waveform: cycle 0 idle, then nf frames built from the framing rules
  task automatic model(input int inst, input int nf);
    int   t;
    logic par;
    logic bits[$];
    for (int k = 0; k < MAXC; k++) ex[k] = 4'b1000;
    t = 1;
    for (int f = 0; f < nf; f++) begin
      bits = {};
      bits.push_back(1'b0);
      par = odd_of(inst);
      for (int b = 0; b < 8; b++) begin
        bits.push_back(mbytes[f][b]);
        par = par ^ mbytes[f][b];
      end
      if (pen_of(inst)) bits.push_back(par);
      for (int s = 0; s < stop_of(inst); s++) bits.push_back(1'b1);
      ex[t] = 4'b1110;
      ex[t+1] = 4'b1010;
      t = t + 2;
      foreach (bits[i]) begin
        for (int c = 0; c < C; c++) begin
          ex[t] = {bits[i], 1'b0, 1'b1, 1'b0};
          t++;
        end
      end
      ex[t-1][0] = 1'b1;
    end
  endtask

  task automatic begin_test(input int s);
    sel = s;
    fq = {};
    mbytes = {};
    emp_v = 1'b1;
    en_v = 1'b0;
    step();
  endtask

  task automatic test_reset();
    begin_test(0);
    rst = 1'b1;
    load_byte(8'($urandom));
    en_v = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({w_tx, w_rd, w_busy, w_done} !== 12'b111_000_000_000) begin
        errors++;
        $display("FAIL reset_values: tx/rd/busy/done got %b required 111000000000",
                 {w_tx, w_rd, w_busy, w_done});
      end
    end
    checks++;
    if (fq.size() !== 1) begin
      errors++;
      $display("FAIL reset_no_pop: fifo size got %0d required 1", fq.size());
    end
    rst = 1'b0;
    capture(50, -1);
    model(0, 1);
    for (int k = 0; k < 50; k++) begin
      checks++;
      if (cap[k] !== ex[k]) begin
        errors++;
        $display("FAIL reset_release cyc %0d: tx,rd,busy,done got %b required %b", k, cap[k], ex[k]);
      end
    end
  endtask

  task automatic test_single_byte();
    int n_rd;
    begin_test(0);
    load_byte(8'hA5);
    en_v = 1'b1;
    capture(50, -1);
    model(0, 1);
    n_rd = 0;
    for (int k = 0; k < 50; k++) begin
      n_rd += int'(cap[k][2]);
      checks++;
      if (cap[k] !== ex[k]) begin
        errors++;
        $display("FAIL single_byte cyc %0d: tx,rd,busy,done got %b required %b", k, cap[k], ex[k]);
      end
    end
    checks++;
    if (n_rd !== 1 || cap[1][2] !== 1'b1) begin
      errors++;
      $display("FAIL single_rd_en: pulses got %0d (cycle1=%b) required 1 at cycle 1", n_rd, cap[1][2]);
    end
    checks++;
    if ({cap[42][0], cap[42][1], cap[43][1]} !== 3'b110) begin
      errors++;
      $display("FAIL single_done_busy: done42,busy42,busy43 got %b required 110",
               {cap[42][0], cap[42][1], cap[43][1]});
    end
  endtask

  task automatic test_back_to_back();
    int n_rd;
    begin_test(0);
    load_byte(8'h01);
    load_byte(8'h02);
    load_byte(8'h03);
    en_v = 1'b1;
    capture(140, -1);
    model(0, 3);
    n_rd = 0;
    for (int k = 0; k < 140; k++) begin
      n_rd += int'(cap[k][2]);
      checks++;
      if (cap[k] !== ex[k]) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: tx,rd,busy,done got %b required %b", k, cap[k], ex[k]);
      end
    end
    checks++;
    if (n_rd !== 3) begin
      errors++;
      $display("FAIL b2b_rd_count: got %0d required 3", n_rd);
    end
  endtask

  task automatic test_parity_stop();
    begin_test(1);
    load_byte(8'h07);
    en_v = 1'b1;
    capture(60, -1);
    model(1, 1);
    for (int k = 0; k < 60; k++) begin
      checks++;
      if (cap[k] !== ex[k]) begin
        errors++;
        $display("FAIL parity_even_2stop cyc %0d: tx,rd,busy,done got %b required %b", k, cap[k], ex[k]);
      end
    end
    checks++;
    if ({cap[40][3], cap[50][0], cap[51][1]} !== 3'b110) begin
      errors++;
      $display("FAIL even_parity_frame48: parity,done50,busy51 got %b required 110",
               {cap[40][3], cap[50][0], cap[51][1]});
    end
    begin_test(2);
    load_byte(8'h07);
    en_v = 1'b1;
    capture(55, -1);
    model(2, 1);
    for (int k = 0; k < 55; k++) begin
      checks++;
      if (cap[k] !== ex[k]) begin
        errors++;
        $display("FAIL parity_odd cyc %0d: tx,rd,busy,done got %b required %b", k, cap[k], ex[k]);
      end
    end
    checks++;
    if ({cap[40][3], cap[46][0]} !== 2'b01) begin
      errors++;
      $display("FAIL odd_parity_bit: parity,done46 got %b required 01", {cap[40][3], cap[46][0]});
    end
  endtask

  task automatic test_enable_drop();
    begin_test(0);
    for (int i = 0; i < 3; i++) load_byte(8'($urandom));
    en_v = 1'b1;
    capture(60, 15);
    model(0, 1);
    for (int k = 0; k < 60; k++) begin
      checks++;
      if (cap[k] !== ex[k]) begin
        errors++;
        $display("FAIL enable_drop cyc %0d: tx,rd,busy,done got %b required %b", k, cap[k], ex[k]);
      end
    end
    checks++;
    if (fq.size() !== 2) begin
      errors++;
      $display("FAIL enable_drop_left: fifo size got %0d required 2", fq.size());
    end
    void'(mbytes.pop_front());
    en_v = 1'b1;
    capture(100, -1);
    model(0, 2);
    for (int k = 0; k < 100; k++) begin
      checks++;
      if (cap[k] !== ex[k]) begin
        errors++;
        $display("FAIL enable_resume cyc %0d: tx,rd,busy,done got %b required %b", k, cap[k], ex[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    begin_test(0);
    load_byte(8'($urandom) & 8'hF7);  // data bit 3 low so the reset edge is visible
    load_byte(8'($urandom));
    en_v = 1'b1;
    capture(20, -1);                  // now inside data bit 3 (cycles 19..22)
    checks++;
    if (w_tx[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_frame_bit3: tx got %b required 0", w_tx[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({w_tx[0], w_rd[0], w_busy[0], w_done[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_immediate: tx,rd,busy,done got %b required 1000",
               {w_tx[0], w_rd[0], w_busy[0], w_done[0]});
    end
    step();
    rst = 1'b0;
    void'(mbytes.pop_front());
    capture(50, -1);
    model(0, 1);
    for (int k = 0; k < 50; k++) begin
      checks++;
      if (cap[k] !== ex[k]) begin
        errors++;
        $display("FAIL after_abort cyc %0d: tx,rd,busy,done got %b required %b", k, cap[k], ex[k]);
      end
    end
    checks++;
    if (fq.size() !== 0) begin
      errors++;
      $display("FAIL after_abort_fifo: fifo size got %0d required 0", fq.size());
    end
  endtask

  task automatic test_random();
    int s, n, len;
    for (int it = 0; it < 4; it++) begin
      s = int'($urandom_range(0, 2));
      n = int'($urandom_range(1, 3));
      begin_test(s);
      for (int i = 0; i < n; i++) load_byte(8'($urandom));
      en_v = 1'b1;
      len = 1 + n * (2 + (9 + int'(pen_of(s)) + stop_of(s)) * C) + 6;
      capture(len, -1);
      model(s, n);
      for (int k = 0; k < len; k++) begin
        checks++;
        if (cap[k] !== ex[k]) begin
          errors++;
          $display("FAIL random inst %0d cyc %0d: tx,rd,busy,done got %b required %b", s, k, cap[k], ex[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = 0;
    en_v = 1'b0;
    emp_v = 1'b1;
    dat_v = 8'h00;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity_stop();
    test_enable_drop();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmit stage that drains the 64-entry byte FIFO and sends each byte as an asynchronous UART frame on a single line. It sits directly downstream of the FIFO, driving its read enable and consuming its registered read-data output. It issues exactly one pop per frame and never pops while the FIFO reports empty.

## Interface

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit; legal range ≥ 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  permits starting a new frame; it has no effect on a frame already in progress.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  8  FIFO read data, valid the cycle after a pop.
- fifo_rd_en  out  1  FIFO pop strobe, high for one cycle per frame.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever the state is not IDLE.
- tx_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

## Operation

- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP.
- **IDLE**: tx=1. If enable=1 and fifo_empty=0, go to POP.
- **POP**: fifo_rd_en=1 for this cycle only. Go to LOAD.
- **LOAD**: capture fifo_data into an 8-bit shift register and compute the parity bit. Go to START.
- **START**: tx=0 for CLKS_PER_BIT cycles.
- **DATA**: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index wraps 7→0 on exit.
- **PARITY**: entered only if PARITY_EN=1. The bit is XOR of the data bits for even parity, or its inverse for odd parity.
- **STOP**: tx=1 for STOP_BITS×CLKS_PER_BIT cycles. tx_done pulses on the final cycle.
- **Exit from STOP**: go to POP if enable=1 and fifo_empty=0, otherwise go to IDLE.
- **Outputs are registered**:
  - tx is registered; fifo_rd_en is decoded from the registered state.
  - No combinational path exists from fifo_empty or enable to any output.
- **Bit timer**:
  - Down-counter of width $clog2(CLKS_PER_BIT), loaded with CLKS_PER_BIT-1 at each bit start.
  - Advance to the next bit when the count reaches 0.
- **Empty safety**: fifo_empty is sampled in IDLE or in the last STOP cycle. fifo_rd_en is asserted only on the cycle after fifo_empty was sampled low. Because this block is the sole reader, no pop can be issued to an empty FIFO.
- **enable deasserted mid-frame**: the current frame completes normally, then the block goes to IDLE.
- **fifo_data changes outside LOAD**: ignored.

## Timing

- **Reset values**: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, counters=0.
- **Reset mid-frame**: the line returns high immediately; the in-flight byte is lost and is not re-popped.
- **Start latency**: enable=1 and fifo_empty=0 are sampled in IDLE at cycle 0. POP is cycle 1, LOAD is cycle 2, and the start bit begins at cycle 3.
- **Frame length**: (1 + 8 + PARITY_EN + STOP_BITS)×CLKS_PER_BIT cycles, measured from the first start-bit cycle.
- **Back-to-back frames**: exactly 2 extra idle-high cycles (POP, LOAD) separate the last stop-bit cycle from the next start bit.
- **busy**: high from POP through the final STOP cycle.

## Structure

- **Shared package uart_pkg** holds:
  - the state enum (tx_state_t);
  - parity-sense constants PAR_EVEN/PAR_ODD;
  - the default baud-divisor constant.
- **Sub-module uart_bit_timer**:
  - Parameter: CLKS_PER_BIT.
  - Inputs: clk, rst, load. Output: tick.
  - It is reused by the planned receive stage.

## Test plan

All scenarios use CLKS_PER_BIT=4.

1. **Reset**: assert rst with FIFO non-empty and enable=1 -> tx=1, fifo_rd_en=0, busy=0, tx_done=0. No pop occurs until the cycle after rst deasserts.
2. **Single byte**: FIFO holds 0xA5, enable=1, PARITY_EN=0 ->
   - exactly one fifo_rd_en pulse, at cycle 1;
   - tx=0 for cycles 3–6;
   - then bits 1,0,1,0,0,1,0,1, 4 cycles each;
   - stop bit high for 4 cycles;
   - tx_done pulses at cycle 42; busy falls at cycle 43.
3. **Back-to-back**: FIFO holds 0x01, 0x02, 0x03 -> three rd_en pulses, frames decode correctly in order, 2 high cycles between frames, return to IDLE after the third tx_done.
4. **Parity and stop bits**: PARITY_EN=1, byte 0x07 -> parity bit 1 for even parity, 0 for odd parity. With STOP_BITS=2, the stop period is 8 cycles and the frame is 48 cycles.
5. **enable drop**: enable goes low during DATA of frame 1 while 2 bytes remain in the FIFO -> frame 1 completes, no further rd_en, block stays in IDLE until enable=1.
6. **Reset mid-frame**: rst pulses during data bit 3 -> tx=1 in the same cycle. After release with the FIFO non-empty, a new pop and a full frame follow, and the aborted byte is not re-sent.
